envelope_generator: RTL and testbench
=====================================

ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16, clocks per envelope update tick (legal 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port gate  input  1  note-on level; high = key held.
REQ-005 SHALL have port attack_rate  input  8  attack step, increment = attack_rate+1 per tick.
REQ-006 SHALL have port decay_rate  input  8  decay step, decrement = decay_rate+1 per tick.
REQ-007 SHALL have port sustain_level  input  8  sustain target, upper byte of accumulator.
REQ-008 SHALL have port release_rate  input  8  release step, decrement = release_rate+1 per tick.
REQ-009 SHALL have port envelope_value  output  8  envelope amplitude, feeds amplitude_modulator envelope_value.
REQ-010 SHALL have port env_state  output  3  current state code.
REQ-011 SHALL have port env_active  output  1  high whenever env_state != IDLE.

Function
REQ-012 SHALL hold a 16-bit unsigned accumulator acc; envelope_value SHALL equal acc[15:8] directly from the register (zero combinational latency from acc).
REQ-013 SHALL generate tick from a free-running counter 0..TICK_DIV-1, tick high for one clock when counter == TICK_DIV-1; TICK_DIV=1 SHALL tick every clock.
REQ-014 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 Gate transitions (checked every clock, independent of tick): IDLE or RELEASE with gate=1 -> ATTACK; ATTACK, DECAY or SUSTAIN with gate=0 -> RELEASE.
REQ-016 On a clock where a gate transition fires, acc SHALL NOT change, even if tick is high (gate wins).
REQ-017 Retrigger SHALL start ATTACK from the current acc value; acc is never forced to zero on gate rise.
REQ-018 ATTACK on tick: if acc + (attack_rate+1) >= 0xFFFF (17-bit compare), acc <= 0xFFFF and state -> DECAY; else acc += attack_rate+1.
REQ-019 DECAY on tick: target T = {sustain_level, 8'h00}; if acc < (decay_rate+1) or acc - (decay_rate+1) <= T, acc <= T and state -> SUSTAIN; else acc -= decay_rate+1.
REQ-020 SUSTAIN SHALL load acc <= {sustain_level, 8'h00} every clock, tracking live sustain_level changes (up or down).
REQ-021 RELEASE on tick: if acc <= (release_rate+1), acc <= 0 and state -> IDLE; else acc -= release_rate+1.
REQ-022 IDLE SHALL hold acc unchanged (0 after a completed release).
REQ-023 No arithmetic SHALL wrap: all add/subtract saturate per REQ-018..021.
REQ-024 sustain_level=0x00 SHALL decay to 0 and remain in SUSTAIN with envelope_value=0, env_active=1.
REQ-025 Rate/level inputs SHALL be sampled combinationally at each update; mid-phase changes take effect on the next tick.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, acc=0, tick counter=0; envelope_value=0x00, env_state=0, env_active=0.
REQ-027 Reset mid-phase SHALL abort immediately; after release with gate=1, ATTACK begins on the first rising clk edge from acc=0.

Structure
REQ-028 State codes (IDLE..RELEASE) and width constants SHALL live in shared package/include synth_pkg, reused by bench and top-level register map.
REQ-029 The tick prescaler SHALL be a sub-module envelope_tick_divider (parameter TICK_DIV, ports clk, rst_n, tick).

Verification (TICK_DIV=1)
REQ-030 Reset: rst_n=0 with gate=1 -> envelope_value=0x00, env_state=0 within same cycle, no clk needed.
REQ-031 Attack: attack_rate=0xFF, gate 0->1 -> ATTACK next edge; envelope_value=0x80 after 128 further clocks; 0xFF and env_state=DECAY after 256.
REQ-032 Decay/sustain: decay_rate=0xFF, sustain_level=0x80 after full attack -> envelope_value reaches 0x80 in 127 clocks, env_state=SUSTAIN; sustain_level changed to 0x40 -> envelope_value=0x40 next clock.
REQ-033 Release: gate 1->0 in SUSTAIN at 0x40, release_rate=0xFF -> RELEASE next edge with value unchanged; 0x00 and IDLE, env_active=0 after 64 further clocks.
REQ-034 Retrigger: gate re-raised in RELEASE at 0x20 -> ATTACK resumes from 0x20, not 0x00.
REQ-035 Chain check: envelope_value driving amplitude_modulator with waveform 0xFF, master 0xFF -> modulator output tracks envelope within ±3 LSB, 0x00 in IDLE.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and state encoding for the envelope generator.
// The bench and the top-level register map import the same definitions.
package synth_pkg;

   localparam int ENV_W   = 8;
   localparam int ACC_W   = 16;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

endpackage

// File: rtl/envelope_tick_divider.sv
// Free-running prescaler: pulses tick for one clock every TICK_DIV clocks.
// TICK_DIV = 1 gives a tick on every clock.
module envelope_tick_divider #(
   parameter int unsigned TICK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   logic [15:0] cnt;

   assign tick = (cnt == 16'(TICK_DIV - 1));

   // NOTE: async reset and <= for all state; reads of cnt in this block see the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/envelope_generator.sv
// ADSR envelope generator: 16-bit saturating accumulator stepped on prescaled ticks,
// with gate edges taking priority over any accumulator update on the same clock.
module envelope_generator
   import synth_pkg::*;
#(
   parameter int unsigned TICK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gate,
   input  logic [7:0] attack_rate,
   input  logic [7:0] decay_rate,
   input  logic [7:0] sustain_level,
   input  logic [7:0] release_rate,
   output logic [7:0] envelope_value,
   output logic [2:0] env_state,
   output logic       env_active
);

   env_state_t        state;
   logic [ACC_W-1:0]  acc;
   logic              tick;

   logic [ACC_W:0]    att_sum;
   logic [ACC_W-1:0]  dec_step;
   logic [ACC_W-1:0]  rel_step;
   logic [ACC_W-1:0]  sus_target;
   logic              att_done;
   logic              dec_done;
   logic              rel_done;

   envelope_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Saturation decisions are made before subtracting so nothing can wrap.
   assign att_sum    = {1'b0, acc} + {9'd0, attack_rate} + 17'd1;
   assign dec_step   = {8'd0, decay_rate} + 16'd1;
   assign rel_step   = {8'd0, release_rate} + 16'd1;
   assign sus_target = {sustain_level, 8'h00};
   assign att_done   = (att_sum >= 17'h0FFFF);
   assign dec_done   = (acc < dec_step) || ((acc - dec_step) <= sus_target);
   assign rel_done   = (acc <= rel_step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         acc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gate) state <= ST_ATTACK;
            end
            ST_ATTACK: begin
               if (!gate) begin
                  state <= ST_RELEASE;
               end else if (tick) begin
                  if (att_done) begin
                     acc   <= 16'hFFFF;
                     state <= ST_DECAY;
                  end else begin
                     acc <= att_sum[ACC_W-1:0];
                  end
               end
            end
            ST_DECAY: begin
               if (!gate) begin
                  state <= ST_RELEASE;
               end else if (tick) begin
                  if (dec_done) begin
                     acc   <= sus_target;
                     state <= ST_SUSTAIN;
                  end else begin
                     acc <= acc - dec_step;
                  end
               end
            end
            ST_SUSTAIN: begin
               if (!gate) state <= ST_RELEASE;
               else       acc   <= sus_target;
            end
            ST_RELEASE: begin
               if (gate) begin
                  state <= ST_ATTACK;
               end else if (tick) begin
                  if (rel_done) begin
                     acc   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     acc <= acc - rel_step;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign envelope_value = acc[ACC_W-1:ACC_W-ENV_W];
   assign env_state      = state;
   assign env_active     = (state != ST_IDLE);

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator at TICK_DIV=1, plus a TICK_DIV=3 instance
// to confirm the prescaler rate.
module tb_envelope_generator;
   import synth_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gate = 1'b1;
   logic       gate4 = 1'b0;
   logic [7:0] attack_rate = 8'hFF;
   logic [7:0] decay_rate = 8'hFF;
   logic [7:0] sustain_level = 8'h80;
   logic [7:0] release_rate = 8'hFF;
   logic [7:0] envelope_value, envelope_value4;
   logic [2:0] env_state, env_state4;
   logic       env_active, env_active4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   envelope_generator #(.TICK_DIV(1)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .gate           (gate),
      .attack_rate    (attack_rate),
      .decay_rate     (decay_rate),
      .sustain_level  (sustain_level),
      .release_rate   (release_rate),
      .envelope_value (envelope_value),
      .env_state      (env_state),
      .env_active     (env_active)
   );

   envelope_generator #(.TICK_DIV(3)) u_dut_slow (
      .clk            (clk),
      .rst_n          (rst_n),
      .gate           (gate4),
      .attack_rate    (attack_rate),
      .decay_rate     (decay_rate),
      .sustain_level  (sustain_level),
      .release_rate   (release_rate),
      .envelope_value (envelope_value4),
      .env_state      (env_state4),
      .env_active     (env_active4)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_env(input string tag, input int val, input env_state_t st);
      check({tag, "_val"}, int'(envelope_value), val);
      check({tag, "_st"}, int'(env_state), int'(st));
   endtask

   initial begin
      #2;
      check_env("reset_async", 8'h00, ST_IDLE);
      check("reset_active", int'(env_active), 0);

      gate = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      check_env("idle", 8'h00, ST_IDLE);
      check("idle_active", int'(env_active), 0);

      gate = 1'b1;
      step(1);
      check_env("atk_entry", 8'h00, ST_ATTACK);
      check("atk_active", int'(env_active), 1);
      step(128);
      check_env("atk_half", 8'h80, ST_ATTACK);
      step(128);
      check_env("atk_full", 8'hFF, ST_DECAY);

      step(127);
      check("dec_127", int'(envelope_value), 8'h80);
      step(1);
      check_env("sus_80", 8'h80, ST_SUSTAIN);
      sustain_level = 8'h40;
      step(1);
      check_env("sus_40", 8'h40, ST_SUSTAIN);

      gate = 1'b0;
      step(1);
      check_env("rel_entry", 8'h40, ST_RELEASE);
      step(63);
      check_env("rel_63", 8'h01, ST_RELEASE);
      step(1);
      check_env("rel_done", 8'h00, ST_IDLE);
      check("rel_active", int'(env_active), 0);

      gate = 1'b1;
      step(257);
      check_env("atk2_full", 8'hFF, ST_DECAY);
      step(200);
      check_env("sus2_40", 8'h40, ST_SUSTAIN);
      gate = 1'b0;
      step(1);
      check_env("rel2_entry", 8'h40, ST_RELEASE);
      step(32);
      check_env("rel2_20", 8'h20, ST_RELEASE);
      gate = 1'b1;
      step(1);
      check_env("retrig", 8'h20, ST_ATTACK);
      step(1);
      check_env("retrig_step", 8'h21, ST_ATTACK);

      // Mid-attack reset with gate held: immediate abort, then restart from zero.
      rst_n = 1'b0;
      #1;
      check_env("midreset", 8'h00, ST_IDLE);
      check("midreset_active", int'(env_active), 0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_env("post_reset", 8'h00, ST_ATTACK);
      step(1);
      check_env("post_reset_step", 8'h01, ST_ATTACK);

      gate = 1'b0;
      step(1);
      check_env("atk_gate_off", 8'h01, ST_RELEASE);
      gate = 1'b1;
      step(1);
      check_env("rel_gate_on", 8'h01, ST_ATTACK);

      sustain_level = 8'h00;
      step(600);
      check_env("sus_zero", 8'h00, ST_SUSTAIN);
      check("sus_zero_active", int'(env_active), 1);
      sustain_level = 8'h90;
      step(1);
      check_env("sus_up", 8'h90, ST_SUSTAIN);

      attack_rate = 8'hFF;
      gate4 = 1'b1;
      step(1);
      check("slow_entry_st", int'(env_state4), int'(ST_ATTACK));
      check("slow_entry_val", int'(envelope_value4), 8'h00);
      step(30);
      check("slow_30_val", int'(envelope_value4), 8'h0A);
      check("slow_30_st", int'(env_state4), int'(ST_ATTACK));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
